// File: rtl/control_unit_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the 8-bit micro controller: opcodes, operand-select bit,
// ALU flag indices and sequencer state encoding.
package control_unit_pkg;

    // ALU class: opcode[7:4]==0, opcode[3] selects memory (X) or immediate operand
    localparam logic [7:0] OP_LOAD_I  = 8'h00;
    localparam logic [7:0] OP_ADD_I   = 8'h01;
    localparam logic [7:0] OP_SUB_I   = 8'h02;
    localparam logic [7:0] OP_AND_I   = 8'h03;
    localparam logic [7:0] OP_LOAD_X  = 8'h08;
    localparam logic [7:0] OP_ADD_X   = 8'h09;
    localparam logic [7:0] OP_SUB_X   = 8'h0A;
    localparam logic [7:0] OP_AND_X   = 8'h0B;
    localparam logic [7:0] OP_STORE_X = 8'h20;
    localparam logic [7:0] OP_JMP     = 8'h30;
    localparam logic [7:0] OP_JZ      = 8'h31;
    localparam logic [7:0] OP_JC      = 8'h32;
    localparam logic [7:0] OP_JN      = 8'h33;
    localparam logic [7:0] OP_JV      = 8'h34;
    localparam logic [7:0] OP_HALT    = 8'h3F;

    localparam int   ALU_OPER2_BIT = 3;
    localparam logic ALU_OPER2_X   = 1'b1;

    localparam int CARRY = 0;
    localparam int OV    = 1;
    localparam int ZERO  = 2;
    localparam int NEG   = 3;

    typedef enum logic [2:0] {
        FETCH_OP  = 3'd0,
        FETCH_ARG = 3'd1,
        READ_MEM  = 3'd2,
        EXEC      = 3'd3,
        WRITE_MEM = 3'd4,
        HALT      = 3'd5
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op_class);
        return (op_class == 4'h0);
    endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
`timescale 1ns/1ps
// Branch resolution: flags which opcodes are jumps and whether the jump is taken
// given the current ALU flags.
module branch_cond
    import control_unit_pkg::*;
#(
    parameter int N_ADDRESS = 8
) (
    input  logic [N_ADDRESS-1:0] ir,
    input  logic [3:0]           flags,
    output logic                 take_jump,
    output logic                 is_jump
);

    // Decode jump opcodes against the flag they test
    always_comb begin
        take_jump = 1'b0;
        is_jump   = 1'b1;
        case (ir)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = flags[ZERO];
            OP_JC:   take_jump = flags[CARRY];
            OP_JN:   take_jump = flags[NEG];
            OP_JV:   take_jump = flags[OV];
            default: is_jump   = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
`timescale 1ns/1ps
// Fetch/decode/sequence controller: fetches opcode+operand over one handshaked
// port, reads memory operands, strobes the ALU, stores AR and resolves branches.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_ADDRESS = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    output logic [N_ADDRESS-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_ack,
    input  logic [WIDTH-1:0]     AR,
    input  logic [3:0]           Flags,
    output logic [N_ADDRESS-1:0] IR,
    output logic [WIDTH-1:0]     IBR,
    output logic [WIDTH-1:0]     MBR,
    output logic                 Exec,
    output logic [N_ADDRESS-1:0] pc,
    output logic                 halted
);

    state_t                 state_r;
    logic [N_ADDRESS-1:0]   pc_inc_s;
    logic                   take_jump_s;
    logic                   is_jump_s;

    assign pc_inc_s  = pc + N_ADDRESS'(1);
    assign mem_wdata = AR;

    branch_cond #(
        .N_ADDRESS (N_ADDRESS)
    ) u_branch_cond (
        .ir        (IR),
        .flags     (Flags),
        .take_jump (take_jump_s),
        .is_jump   (is_jump_s)
    );

    // Sequencer state, program counter and instruction/operand registers
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r <= FETCH_OP;
            pc      <= '0;
            IR      <= '0;
            IBR     <= '0;
            MBR     <= '0;
        end else begin
            case (state_r)
                FETCH_OP: begin
                    if (mem_ack) begin
                        IR      <= mem_rdata;
                        pc      <= pc_inc_s;
                        state_r <= FETCH_ARG;
                    end
                end
                FETCH_ARG: begin
                    if (mem_ack) begin
                        IBR <= mem_rdata;
                        // Flags are sampled here, after the previous Exec committed
                        if (is_jump_s && take_jump_s) begin
                            pc <= mem_rdata;
                        end else begin
                            pc <= pc_inc_s;
                        end
                        if (is_alu_op(IR[7:4])) begin
                            state_r <= (IR[ALU_OPER2_BIT] == ALU_OPER2_X) ? READ_MEM : EXEC;
                        end else if (IR == OP_STORE_X) begin
                            state_r <= WRITE_MEM;
                        end else if (IR == OP_HALT) begin
                            state_r <= HALT;
                        end else begin
                            state_r <= FETCH_OP;
                        end
                    end
                end
                READ_MEM: begin
                    if (mem_ack) begin
                        MBR     <= mem_rdata;
                        state_r <= EXEC;
                    end
                end
                EXEC:      state_r <= FETCH_OP;
                WRITE_MEM: begin
                    if (mem_ack) begin
                        state_r <= FETCH_OP;
                    end
                end
                HALT:      state_r <= HALT;
                default:   state_r <= FETCH_OP;
            endcase
        end
    end

    // Moore decode of the memory port and strobes; requests are gated off during reset
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc;
        Exec     = 1'b0;
        halted   = 1'b0;
        case (state_r)
            FETCH_OP, FETCH_ARG: mem_rd = ~arst;
            READ_MEM: begin
                mem_rd   = ~arst;
                mem_addr = IBR;
            end
            WRITE_MEM: begin
                mem_wr   = ~arst;
                mem_addr = IBR;
            end
            EXEC:    Exec   = 1'b1;
            HALT:    halted = 1'b1;
            default: mem_addr = pc;
        endcase
    end

endmodule
